// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock enable, X/Y counters, syncs and blanking.
// Ports: Clk, Reset (sync, active-high) in; VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
//        VGA_SYNC_N, DrawX, DrawY, pix_en, frame_start out.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_en,
    output logic       frame_start
);

    // Last counter values before wrap
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds kept at 11 bits so a sync ending at 1024 still compares
    localparam logic [10:0] H_VIS = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SE  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [10:0] xw;
    logic [10:0] yw;
    logic        pe;
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        fs;
    logic        wrap_frame;

    assign wrap_frame = pe && (x == H_LAST) && (y == V_LAST);

    // Next counter values; only move on pixel-enable cycles
    always_comb begin
        x_next = x;
        y_next = y;
        if (pe) begin
            if (x == H_LAST) begin
                x_next = 10'd0;
                if (y == V_LAST) begin
                    y_next = 10'd0;
                end else begin
                    y_next = y + 10'd1;
                end
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    assign xw = {1'b0, x_next};
    assign yw = {1'b0, y_next};

    // Syncs and blanking derive from the next counts so they
    // line up with DrawX/DrawY on the same cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pe      <= 1'b0;
            vclk    <= 1'b0;
            x       <= 10'd0;
            y       <= 10'd0;
            hs      <= 1'b1;
            vs      <= 1'b1;
            blank_n <= 1'b1;
            fs      <= 1'b0;
        end else begin
            pe      <= ~pe;
            vclk    <= ~pe;
            x       <= x_next;
            y       <= y_next;
            hs      <= !((xw >= H_SS) && (xw < H_SE));
            vs      <= !((yw >= V_SS) && (yw < V_SE));
            blank_n <= (xw < H_VIS) && (yw < V_VIS);
            fs      <= wrap_frame;
        end
    end

    assign VGA_CLK     = vclk;
    assign VGA_HS      = hs;
    assign VGA_VS      = vs;
    assign VGA_BLANK_N = blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = x;
    assign DrawY       = y;
    assign pix_en      = pe;
    assign frame_start = fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a small-raster instance and a default
// instance, both checked every Clk against a closed-form timing model.
module tb_vga_timing_gen;

    // Small raster so many whole frames fit in the run
    localparam int SHV = 16, SHF = 2, SHS = 4, SHT = 24;
    localparam int SVV = 10, SVF = 2, SVS = 2, SVT = 16;
    localparam int NCYC = 8000;

    typedef struct packed {
        logic       pe;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       syn;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic Clk = 1'b1;
    logic Reset = 1'b1;

    logic       s_clk, s_hs, s_vs, s_bn, s_syn, s_pe, s_fs;
    logic [9:0] s_x, s_y;
    logic       d_clk, d_hs, d_vs, d_bn, d_syn, d_pe, d_fs;
    logic [9:0] d_x, d_y;

    int tests = 0;
    int fails = 0;
    int fs_seen = 0;
    obs_t q_s[$];
    obs_t q_d[$];

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_TOTAL(SHT),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_TOTAL(SVT)
    ) dut_s (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(s_clk), .VGA_HS(s_hs),
        .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_syn),
        .DrawX(s_x), .DrawY(s_y), .pix_en(s_pe), .frame_start(s_fs)
    );

    vga_timing_gen dut_d (
        .Clk(Clk), .Reset(Reset), .VGA_CLK(d_clk), .VGA_HS(d_hs),
        .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_syn),
        .DrawX(d_x), .DrawY(d_y), .pix_en(d_pe), .frame_start(d_fs)
    );

    // n = number of non-reset edges since the last reset edge.
    // Pixel index advances every second Clk, first move on edge 2.
    function automatic obs_t model(input int n,
                                   input int hv, input int hf,
                                   input int hsw, input int ht,
                                   input int vv, input int vf,
                                   input int vsw, input int vt);
        obs_t o;
        int p, x, y;
        p = n / 2;
        x = p % ht;
        y = (p / ht) % vt;
        o.pe   = (n % 2) == 1;
        o.vclk = (n % 2) == 1;
        o.hs   = !(x >= hv + hf && x < hv + hf + hsw);
        o.vs   = !(y >= vv + vf && y < vv + vf + vsw);
        o.bn   = (x < hv) && (y < vv);
        o.syn  = 1'b0;
        o.fs   = (n > 0) && (n % 2 == 0) && (p % (ht * vt) == 0);
        o.x    = 10'(x);
        o.y    = 10'(y);
        return o;
    endfunction

    // Stimulus: choose Reset before each edge and queue the expected result
    initial begin
        int n;
        int rst_left;
        n = 0;
        rst_left = 3;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge Clk);
            if (c == 3000 || c == 5237) rst_left = 2;
            else if (rst_left == 0 && $urandom_range(1999) == 0)
                rst_left = $urandom_range(3, 1);
            Reset = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            n = Reset ? 0 : n + 1;
            q_s.push_back(model(n, SHV, SHF, SHS, SHT,
                                SVV, SVF, SVS, SVT));
            q_d.push_back(model(n, 640, 16, 96, 800,
                                480, 10, 2, 525));
        end
        for (int w = 0; w < 10 && (q_s.size() > 0 || q_d.size() > 0); w++)
            @(negedge Clk);
        tests++;
        if (q_s.size() != 0 || q_d.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d left, required 0",
                     q_s.size(), q_d.size());
        end
        tests++;
        if (fs_seen < 5) begin
            fails++;
            $display("FAIL fs_count: %0d frame pulses, required >=5",
                     fs_seen);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: pop and compare shortly after each rising edge
    initial begin
        obs_t e, a;
        forever begin
            @(posedge Clk);
            #2;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                a = '{s_pe, s_clk, s_hs, s_vs, s_bn, s_syn, s_fs, s_x, s_y};
                tests++;
                if (a.fs) fs_seen++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL small @%0t: got x=%0d y=%0d pe%b clk%b hs%b vs%b bn%b sn%b fs%b, required x=%0d y=%0d pe%b clk%b hs%b vs%b bn%b sn%b fs%b",
                             $time, a.x, a.y, a.pe, a.vclk, a.hs, a.vs, a.bn,
                             a.syn, a.fs, e.x, e.y, e.pe, e.vclk, e.hs, e.vs,
                             e.bn, e.syn, e.fs);
                end
            end
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                a = '{d_pe, d_clk, d_hs, d_vs, d_bn, d_syn, d_fs, d_x, d_y};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL dflt @%0t: got x=%0d y=%0d pe%b clk%b hs%b vs%b bn%b sn%b fs%b, required x=%0d y=%0d pe%b clk%b hs%b vs%b bn%b sn%b fs%b",
                             $time, a.x, a.y, a.pe, a.vclk, a.hs, a.vs, a.bn,
                             a.syn, a.fs, e.x, e.y, e.pe, e.vclk, e.hs, e.vs,
                             e.bn, e.syn, e.fs);
                end
            end
        end
    end

endmodule
